// File: rtl/fetch_ctrl_pkg.sv
// Fetch control shared types and codes.
// State encoding plus PC-mux and pop-capture codes.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN,
    INT_PUSH_H,
    INT_PUSH_L,
    INT_JUMP,
    POP_H,
    POP_L,
    RET_JUMP
  } state_t;

  localparam logic [1:0] SEL_PC1  = 2'b00;
  localparam logic [1:0] SEL_RDST = 2'b01;
  localparam logic [1:0] SEL_ISR  = 2'b10;
  localparam logic [1:0] SEL_RET  = 2'b11;

  localparam logic [1:0] POP_NONE = 2'b00;
  localparam logic [1:0] POP_HI   = 2'b10;
  localparam logic [1:0] POP_LO   = 2'b11;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC mux, flush, interrupt
// entry push sequence and RET/RTI pop sequence.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int POP_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       int_req,
  input  logic       branch_taken,
  input  logic       stall,
  input  logic       jmp_d,
  input  logic       ret_d,
  input  logic       rti_d,
  input  logic       pop_valid,
  output logic       pc_enb,
  output logic [1:0] jump_sel,
  output logic [1:0] pop_l_h,
  output logic       flush,
  output logic       push_req,
  output logic       push_hi,
  output logic       int_ack,
  output logic       int_mask,
  output logic       pop_fault
);

  localparam int CB = $clog2(POP_TIMEOUT + 1);
  localparam int CW = (CB > 4) ? CB : 4;
  localparam logic [CW-1:0] LIM =
    CW'(POP_TIMEOUT - 1);

  state_t          state;
  state_t          state_n;
  logic            is_rti;
  logic [CW-1:0]   cnt;
  logic            in_pop;
  logic            timeout;
  logic            int_go;
  logic            ret_go;
  logic            ret_start;

  assign in_pop  = (state == POP_H) ||
                   (state == POP_L);
  assign timeout = in_pop && !pop_valid &&
                   (cnt == LIM);
  assign int_go  = int_req && !int_mask;
  assign ret_go  = ret_d || rti_d;

  assign ret_start = (state == RUN) &&
                     !branch_taken &&
                     !stall && !int_go &&
                     ret_go;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_n;
    end
  end

  // Interrupt mask, RTI flag and pop timeout counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_mask <= 1'b0;
      is_rti   <= 1'b0;
      cnt      <= '0;
    end else begin
      if (state == INT_JUMP) begin
        int_mask <= 1'b1;
      end else if (state == RET_JUMP && is_rti) begin
        int_mask <= 1'b0;
      end
      if (ret_start) begin
        is_rti <= rti_d;
      end
      if (!in_pop || pop_valid) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      RUN: begin
        if (branch_taken || stall) begin
          state_n = RUN;
        end else if (int_go) begin
          state_n = INT_PUSH_H;
        end else if (ret_go) begin
          state_n = POP_H;
        end
      end
      INT_PUSH_H: state_n = INT_PUSH_L;
      INT_PUSH_L: state_n = INT_JUMP;
      INT_JUMP:   state_n = RUN;
      POP_H: begin
        if (branch_taken) begin
          state_n = RUN;
        end else if (pop_valid) begin
          state_n = POP_L;
        end else if (timeout) begin
          state_n = RUN;
        end
      end
      POP_L: begin
        if (branch_taken) begin
          state_n = RUN;
        end else if (pop_valid) begin
          state_n = RET_JUMP;
        end else if (timeout) begin
          state_n = RUN;
        end
      end
      RET_JUMP:   state_n = RUN;
      default:    state_n = RUN;
    endcase
  end

  // Output decode from state and current inputs
  always_comb begin
    pc_enb    = 1'b0;
    jump_sel  = SEL_PC1;
    pop_l_h   = POP_NONE;
    flush     = 1'b1;
    push_req  = 1'b0;
    push_hi   = 1'b0;
    int_ack   = 1'b0;
    pop_fault = 1'b0;
    unique case (state)
      RUN: begin
        if (branch_taken) begin
          pc_enb = 1'b1;
          flush  = 1'b0;
        end else if (stall) begin
          flush  = 1'b0;
        end else if (int_go || ret_go) begin
          pc_enb = 1'b0;
        end else if (jmp_d) begin
          pc_enb   = 1'b1;
          jump_sel = SEL_RDST;
        end else begin
          pc_enb = 1'b1;
          flush  = 1'b0;
        end
      end
      INT_PUSH_H: begin
        push_req = 1'b1;
        push_hi  = 1'b1;
      end
      INT_PUSH_L: begin
        push_req = 1'b1;
      end
      INT_JUMP: begin
        pc_enb   = 1'b1;
        jump_sel = SEL_ISR;
        int_ack  = 1'b1;
      end
      POP_H, POP_L: begin
        if (branch_taken) begin
          pc_enb = 1'b1;
          flush  = 1'b0;
        end else if (pop_valid) begin
          pop_l_h = (state == POP_H) ?
                    POP_HI : POP_LO;
        end else if (timeout) begin
          pop_fault = 1'b1;
        end
      end
      RET_JUMP: begin
        pc_enb   = 1'b1;
        jump_sel = SEL_RET;
      end
      default: begin
        pc_enb = 1'b0;
      end
    endcase
    if (!rst) begin
      pc_enb    = 1'b0;
      jump_sel  = SEL_PC1;
      pop_l_h   = POP_NONE;
      flush     = 1'b1;
      push_req  = 1'b0;
      push_hi   = 1'b0;
      int_ack   = 1'b0;
      pop_fault = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: vector table
// plus timeout and mid-sequence reset checks.
module tb_fetch_ctrl;

  typedef struct packed {
    logic int_req;
    logic branch_taken;
    logic stall;
    logic jmp_d;
    logic ret_d;
    logic rti_d;
    logic pop_valid;
  } in_t;

  typedef struct packed {
    logic       pc_enb;
    logic [1:0] jsel;
    logic [1:0] plh;
    logic       flush;
    logic       push_req;
    logic       push_hi;
    logic       int_ack;
    logic       int_mask;
    logic       pop_fault;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       int_req, branch_taken, stall;
  logic       jmp_d, ret_d, rti_d, pop_valid;
  logic       pc_enb, flush, push_req, push_hi;
  logic       int_ack, int_mask, pop_fault;
  logic [1:0] jump_sel, pop_l_h;

  int tests  = 0;
  int failed = 0;
  vec_t q[$];

  always #5 clk = ~clk;

  fetch_ctrl #(.POP_TIMEOUT(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .int_req      (int_req),
    .branch_taken (branch_taken),
    .stall        (stall),
    .jmp_d        (jmp_d),
    .ret_d        (ret_d),
    .rti_d        (rti_d),
    .pop_valid    (pop_valid),
    .pc_enb       (pc_enb),
    .jump_sel     (jump_sel),
    .pop_l_h      (pop_l_h),
    .flush        (flush),
    .push_req     (push_req),
    .push_hi      (push_hi),
    .int_ack      (int_ack),
    .int_mask     (int_mask),
    .pop_fault    (pop_fault)
  );

  function automatic in_t mi(
    input int ir, input int bt, input int st,
    input int jd, input int rd, input int ri,
    input int pv);
    in_t v;
    v.int_req      = ir[0];
    v.branch_taken = bt[0];
    v.stall        = st[0];
    v.jmp_d        = jd[0];
    v.ret_d        = rd[0];
    v.rti_d        = ri[0];
    v.pop_valid    = pv[0];
    return v;
  endfunction

  function automatic out_t mk(
    input int pc, input int js, input int pl,
    input int fl, input int pr, input int ph,
    input int ia, input int im, input int pf);
    out_t o;
    o.pc_enb    = pc[0];
    o.jsel      = js[1:0];
    o.plh       = pl[1:0];
    o.flush     = fl[0];
    o.push_req  = pr[0];
    o.push_hi   = ph[0];
    o.int_ack   = ia[0];
    o.int_mask  = im[0];
    o.pop_fault = pf[0];
    return o;
  endfunction

  task automatic drive(input in_t v);
    int_req      = v.int_req;
    branch_taken = v.branch_taken;
    stall        = v.stall;
    jmp_d        = v.jmp_d;
    ret_d        = v.ret_d;
    rti_d        = v.rti_d;
    pop_valid    = v.pop_valid;
  endtask

  task automatic check(input string nm,
                       input out_t exp);
    out_t got;
    got = {pc_enb, jump_sel, pop_l_h, flush,
           push_req, push_hi, int_ack,
           int_mask, pop_fault};
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %b required %b",
               nm, got, exp);
    end
  endtask

  task automatic add(input in_t i,
                     input out_t e);
    vec_t v;
    v.i = i;
    v.e = e;
    q.push_back(v);
  endtask

  task automatic cyc(input string nm,
                     input in_t i,
                     input out_t e);
    drive(i);
    #1;
    check(nm, e);
    @(negedge clk);
  endtask

  out_t o_rst, o_run, o_hold;
  in_t  none;

  initial begin
    o_rst  = mk(0,0,0,1,0,0,0,0,0);
    o_run  = mk(1,0,0,0,0,0,0,0,0);
    o_hold = mk(0,0,0,1,0,0,0,0,0);
    none   = mi(0,0,0,0,0,0,0);

    add(none,              o_run);
    add(mi(0,0,1,0,0,0,0), mk(0,0,0,0,0,0,0,0,0));
    add(mi(0,0,0,1,0,0,0), mk(1,1,0,1,0,0,0,0,0));
    add(mi(1,1,1,0,0,0,0), o_run);
    add(mi(1,0,0,0,0,0,0), o_hold);
    add(mi(1,1,0,0,0,0,0), mk(0,0,0,1,1,1,0,0,0));
    add(mi(1,0,0,0,0,0,0), mk(0,0,0,1,1,0,0,0,0));
    add(mi(1,0,0,0,0,0,0), mk(1,2,0,1,0,0,1,0,0));
    add(mi(1,0,0,0,0,0,0), mk(1,0,0,0,0,0,0,1,0));
    add(mi(1,0,0,0,0,1,0), mk(0,0,0,1,0,0,0,1,0));
    add(none,              mk(0,0,0,1,0,0,0,1,0));
    add(none,              mk(0,0,0,1,0,0,0,1,0));
    add(mi(0,0,0,0,0,0,1), mk(0,0,2,1,0,0,0,1,0));
    add(mi(0,0,0,0,0,0,1), mk(0,0,3,1,0,0,0,1,0));
    add(none,              mk(1,3,0,1,0,0,0,1,0));
    add(none,              o_run);
    add(mi(0,0,0,0,1,0,0), o_hold);
    add(mi(0,1,0,0,0,0,1), o_run);
    add(none,              o_run);
    add(mi(0,0,0,1,1,0,0), o_hold);
    add(mi(0,0,0,0,0,0,1), mk(0,0,2,1,0,0,0,0,0));
    add(mi(0,0,1,0,0,0,0), o_hold);
    add(mi(0,1,0,0,0,0,0), o_run);
    add(none,              o_run);

    rst = 1'b0;
    drive(none);
    #2;
    check("reset_outputs", o_rst);
    drive(mi(1,0,0,1,0,0,1));
    #1;
    check("reset_ignores_inputs", o_rst);
    drive(none);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    foreach (q[k]) begin
      cyc($sformatf("vec%0d", k), q[k].i, q[k].e);
    end

    cyc("to_ret", mi(0,0,0,0,1,0,0), o_hold);
    for (int k = 1; k <= 15; k++) begin
      cyc($sformatf("to_wait%0d", k), none,
          (k == 15) ? mk(0,0,0,1,0,0,0,0,1)
                    : o_hold);
    end
    cyc("to_back_run", none, o_run);

    cyc("tl_ret", mi(0,0,0,0,1,0,0), o_hold);
    for (int k = 1; k <= 10; k++) begin
      drive(none);
      @(negedge clk);
    end
    cyc("tl_pv", mi(0,0,0,0,0,0,1),
        mk(0,0,2,1,0,0,0,0,0));
    for (int k = 1; k <= 14; k++) begin
      drive(none);
      @(negedge clk);
    end
    cyc("tl_no_early", none, mk(0,0,0,1,0,0,0,0,1));
    cyc("tl_back_run", none, o_run);

    cyc("rs_int", mi(1,0,0,0,0,0,0), o_hold);
    cyc("rs_push_h", mi(1,0,0,0,0,0,0),
        mk(0,0,0,1,1,1,0,0,0));
    drive(mi(1,0,0,0,0,0,0));
    #1;
    check("rs_push_l", mk(0,0,0,1,1,0,0,0,0));
    rst = 1'b0;
    #1;
    check("rs_async_push", o_rst);
    drive(none);
    @(negedge clk);
    rst = 1'b1;
    cyc("rs_run_after", none, o_run);

    cyc("rp_ret", mi(0,0,0,0,0,1,0), o_hold);
    cyc("rp_pv", mi(0,0,0,0,0,0,1),
        mk(0,0,2,1,0,0,0,0,0));
    drive(mi(0,0,0,0,0,0,1));
    #1;
    rst = 1'b0;
    #1;
    check("rp_async_pop", o_rst);
    @(negedge clk);
    rst = 1'b1;
    cyc("rp_pv_in_run", mi(0,0,0,0,0,0,1), o_run);
    cyc("rp_int_unmasked", mi(1,0,0,0,0,0,0), o_hold);
    cyc("rp_push_h", none, mk(0,0,0,1,1,1,0,0,0));

    $display("[TB] %0d tests run, %0d failed",
             tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter POP_TIMEOUT, default 15: maximum cycles to wait for each popped word before a fault.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port int_req  input  1  interrupt request, level, held until int_ack.
REQ-005 SHALL have port branch_taken  input  1  conditional branch resolved taken in execute.
REQ-006 SHALL have port stall  input  1  decode hazard stall.
REQ-007 SHALL have port jmp_d  input  1  unconditional jump (target Rdst_D) in decode.
REQ-008 SHALL have port ret_d  input  1  RET in decode.
REQ-009 SHALL have port rti_d  input  1  RTI in decode (treated as RET plus unmask).
REQ-010 SHALL have port pop_valid  input  1  WD holds the next popped return-address word.
REQ-011 SHALL have port pc_enb  output  1  PC register enable.
REQ-012 SHALL have port jump_sel  output  2  PC mux select: 00 pc+1, 01 Rdst_D, 10 ISR, 11 popped return address.
REQ-013 SHALL have port pop_l_h  output  2  bit1 capture enable, bit0 0=high word, 1=low word.
REQ-014 SHALL have port flush  output  1  replace fetched instruction with NOP.
REQ-015 SHALL have port push_req / push_hi  output  1 each  request memory to push the PC; push_hi=1 high word.
REQ-016 SHALL have port int_ack / int_mask / pop_fault  output  1 each  entry pulse / interrupts masked / pop timeout pulse.

Function
REQ-017 SHALL implement states RUN, INT_PUSH_H, INT_PUSH_L, INT_JUMP, POP_H, POP_L, RET_JUMP; outputs are decoded from state and inputs in the same cycle.
REQ-018 In RUN, inputs are prioritised as branch_taken > stall > int_req&!int_mask > ret_d|rti_d > jmp_d > none.
REQ-019 RUN with branch_taken SHALL drive pc_enb=1, jump_sel=00, flush=0 (fetch itself overrides the mux and NOPs); no state change; interrupt deferred.
REQ-020 RUN with stall SHALL drive pc_enb=0, flush=0; no state change.
REQ-021 RUN with an unmasked int_req SHALL drive pc_enb=0, flush=1 and go to INT_PUSH_H.
REQ-022 INT_PUSH_H SHALL drive push_req=1, push_hi=1, pc_enb=0, flush=1, then go to INT_PUSH_L; INT_PUSH_L drives the same with push_hi=0, then goes to INT_JUMP.
REQ-023 INT_JUMP SHALL drive jump_sel=10, pc_enb=1, flush=1, int_ack=1 for exactly one cycle, set int_mask, and return to RUN.
REQ-024 RUN with ret_d or rti_d SHALL drive pc_enb=0, flush=1, latch an is_rti flag, clear the timeout counter and go to POP_H.
REQ-025 POP_H SHALL hold pc_enb=0, flush=1; on pop_valid it drives pop_l_h=10 that cycle and goes to POP_L; POP_L drives pop_l_h=11 on pop_valid and goes to RET_JUMP.
REQ-026 RET_JUMP SHALL drive jump_sel=11, pc_enb=1, flush=1 for one cycle, clear int_mask if is_rti, and return to RUN.
REQ-027 RUN with jmp_d only SHALL drive jump_sel=01, pc_enb=1, flush=1 for one cycle; no state change.
REQ-028 RUN with none SHALL drive pc_enb=1, jump_sel=00, flush=0; all other outputs 0 whenever not stated.
REQ-029 A 4-bit-min saturating counter SHALL count cycles in POP_H/POP_L without pop_valid; reaching POP_TIMEOUT pulses pop_fault for one cycle and returns to RUN with pc_enb=0, flush=1.
REQ-030 branch_taken in POP_H/POP_L SHALL abort to RUN (wrong-path RET) with pop_l_h=00; branch_taken in INT_* states is ignored (interrupt entry completes).
REQ-031 int_req SHALL be ignored outside RUN and while int_mask=1; stall SHALL be ignored outside RUN.

Reset
REQ-032 While rst=0 SHALL force state RUN, int_mask=0, is_rti=0, counter=0; outputs pc_enb=0, jump_sel=00, pop_l_h=00, flush=1, push_req=push_hi=int_ack=pop_fault=0.
REQ-033 Reset asserted mid-sequence SHALL abandon it immediately; no partial pop or push completes.

Structure
REQ-034 Package fetch_ctrl_pkg SHALL hold the state enum, jump_sel codes (SEL_PC1, SEL_RDST, SEL_ISR, SEL_RET) and pop_l_h codes (POP_HI, POP_LO).
REQ-035 Single module, no sub-module; fetch instantiates it and wires jump_sel/pop_l_h/pc_enb/flush to JUMP_SEL/POP_L_H/PC_ENB/FLUSH.

Verification
REQ-036 Reset release with no inputs -> cycle 1: pc_enb=1, jump_sel=00, flush=0.
REQ-037 int_req=1 in RUN -> 2 push cycles (push_hi 1 then 0), then jump_sel=10 with int_ack=1; int_mask=1 afterwards; second int_req ignored.
REQ-038 rti_d, pop_valid after 2 and 3 cycles -> pop_l_h=10 then 11, then jump_sel=11, pc_enb=1, int_mask cleared.
REQ-039 ret_d, no pop_valid -> pop_fault pulse after 15 cycles, state RUN.
REQ-040 branch_taken with stall and int_req all 1 in RUN -> pc_enb=1, no int_ack; POP_H with branch_taken -> back to RUN, pop_l_h=00.
